sm_vec_accumulator: RTL and testbench

// - Streaming accumulator that consumes 9-bit sign-magnitude operands (bit 8 = sign, [7:0] = magnitude).
// - Uses the same number format and add/sub semantics as alu_9bit.
// - Folds VEC_LEN operands into one running sum, then presents the result on a valid/ready output.
// - Sits directly downstream of alu_9bit: it consumes ALU results and reduces them into one value per vector.

---
 rtl/sm_vec_accumulator_if.sv | 22 ++
 rtl/sm_vec_accumulator.sv | 121 ++++++++++++
 tb/tb_sm_vec_accumulator.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sm_vec_accumulator_if.sv
// Operand-in / sum-out stream interface for sm_vec_accumulator.
// The slave modport is the accumulator side. The master modport is the producer and consumer side.
interface sm_vec_accumulator_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       in_sub;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic       out_ovf;

  modport slave (
    input  in_valid, in_data, in_sub, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_data, in_sub, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/sm_vec_accumulator.sv
// Streaming sign-magnitude accumulator. It folds VEC_LEN 9-bit operands into one sum per vector.
// Define ACC_SAT_EN to clamp an overflowing magnitude to 255. Otherwise the magnitude wraps mod 256.
module sm_vec_accumulator #(
  parameter int VEC_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  sm_vec_accumulator_if.slave    bus
);

  localparam int CW = $clog2(VEC_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  typedef struct packed {
    logic [8:0] res;
    logic       ovf;
  } step_t;

  // One add/sub step. Sign-magnitude operands; the result is never negative zero.
  function automatic step_t sm_step(input logic [8:0] a, input logic [8:0] b, input logic sub);
    logic       b_sign;
    logic       sign;
    logic [8:0] sum;
    logic [7:0] mag;
    step_t      r;
    b_sign = b[8] ^ sub;
    r.ovf  = 1'b0;
    sum    = {1'b0, a[7:0]} + {1'b0, b[7:0]};
    if (a[8] == b_sign) begin
      r.ovf = sum[8];
      sign  = a[8];
`ifdef ACC_SAT_EN
      mag   = sum[8] ? 8'hFF : sum[7:0];
`else
      mag   = sum[7:0];
`endif
    end else if (a[7:0] >= b[7:0]) begin
      mag  = a[7:0] - b[7:0];
      sign = a[8];
    end else begin
      mag  = b[7:0] - a[7:0];
      sign = b_sign;
    end
    r.res = (mag == 8'h00) ? 9'h000 : {sign, mag};
    return r;
  endfunction

  state_t      state, state_d;
  logic [8:0]  acc, acc_d;
  logic [CW-1:0] count, count_d;
  logic        ovf, ovf_d;
  step_t       step;

  assign step = sm_step(acc, bus.in_data, bus.in_sub);

  // in_ready and out_valid depend on the state register only.
  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = (state == DONE) ? acc : 9'h000;
  assign bus.out_ovf   = (state == DONE) ? ovf : 1'b0;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
    state_d = state;
    acc_d   = acc;
    count_d = count;
    ovf_d   = ovf;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = (bus.in_data == 9'h100) ? 9'h000 : bus.in_data;
          count_d = CW'(1);
          ovf_d   = 1'b0;
          state_d = (VEC_LEN == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc_d   = step.res;
          ovf_d   = ovf | step.ovf;
          count_d = count + CW'(1);
          if (count == CW'(VEC_LEN - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = 9'h000;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // clear overrides any beat in the same cycle.
    if (clear) begin
      state_d = IDLE;
      acc_d   = 9'h000;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 9'h000;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      count <= count_d;
      ovf   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sm_vec_accumulator.sv
// Directed, table-driven bench for sm_vec_accumulator with VEC_LEN=4.
// Expected sums follow ACC_SAT_EN in the same way the design build does.
module tb_sm_vec_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  int   total = 0;
  int   bad   = 0;

  sm_vec_accumulator_if bus ();

  sm_vec_accumulator #(.VEC_LEN(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [8:0] d [4];
    logic [3:0] sub;       // bit i set: operand i is subtracted
    logic [8:0] exp_data;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input string n, input logic [8:0] a, input logic [8:0] b,
                              input logic [8:0] c, input logic [8:0] e, input logic [3:0] s,
                              input logic [8:0] x, input logic o);
    vec_t v;
    v.name = n; v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = e;
    v.sub = s; v.exp_data = x; v.exp_ovf = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [8:0] d, input logic s);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sub = s;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, " out_valid after drain"}, 32'(bus.out_valid), 32'd0);
    check({name, " in_ready after drain"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input logic do_drain);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check({v.name, " early out_valid"}, 32'(bus.out_valid), 32'd0);
      beat(v.d[i], v.sub[i]);
    end
    check({v.name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({v.name, " out_data"}, 32'(bus.out_data), 32'(v.exp_data));
    check({v.name, " out_ovf"}, 32'(bus.out_ovf), 32'(v.exp_ovf));
    if (do_drain) drain(v.name);
  endtask

  initial begin
    logic [8:0] held;
    vec_t ones, v1;
    bus.in_valid = 1'b0; bus.in_data = 9'h000; bus.in_sub = 1'b0; bus.out_ready = 1'b0;

    v1 = mk("add_only", 9'h003, 9'h002, 9'h101, 9'h004, 4'b0000, 9'h008, 1'b0);
    ones = mk("ones", 9'h001, 9'h001, 9'h001, 9'h001, 4'b0000, 9'h004, 1'b0);
    vecs[0] = v1;
    vecs[1] = mk("sub_steps", 9'h103, 9'h102, 9'h000, 9'h000, 4'b0010, 9'h101, 1'b0);
    vecs[2] = mk("cancel_negzero", 9'h005, 9'h105, 9'h100, 9'h000, 4'b0000, 9'h000, 1'b0);
    vecs[6] = mk("mixed_signs", 9'h050, 9'h030, 9'h030, 9'h050, 4'b0110, 9'h040, 1'b0);
`ifdef ACC_SAT_EN
    vecs[3] = mk("overflow", 9'h0C8, 9'h064, 9'h000, 9'h000, 4'b0000, 9'h0FF, 1'b1);
    vecs[4] = mk("ovf_then_sub", 9'h0FF, 9'h101, 9'h105, 9'h005, 4'b1010, 9'h0F5, 1'b1);
    vecs[5] = mk("neg_overflow", 9'h1FF, 9'h1FF, 9'h080, 9'h000, 4'b0100, 9'h1FF, 1'b1);
`else
    vecs[3] = mk("overflow", 9'h0C8, 9'h064, 9'h000, 9'h000, 4'b0000, 9'h02C, 1'b1);
    vecs[4] = mk("ovf_then_sub", 9'h0FF, 9'h101, 9'h105, 9'h005, 4'b1010, 9'h10A, 1'b1);
    vecs[5] = mk("neg_overflow", 9'h1FF, 9'h1FF, 9'h080, 9'h000, 4'b0100, 9'h17E, 1'b1);
`endif

    // Outputs while reset is asserted.
    #2;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_data", 32'(bus.out_data), 32'd0);
    check("reset out_ovf", 32'(bus.out_ovf), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], 1'b1);

    // Backpressure: hold off the output while operands keep arriving.
    run_vec(v1, 1'b0);
    held = bus.out_data;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 9'h007; bus.in_sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp out_data stable", 32'(bus.out_data), 32'(held));
    end
    bus.in_valid = 1'b0;
    drain("bp");
    run_vec(v1, 1'b1);

    // A gap mid-vector holds the partial sum.
    beat(9'h003, 1'b0);
    beat(9'h002, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("gap out_valid", 32'(bus.out_valid), 32'd0);
    beat(9'h101, 1'b0);
    beat(9'h004, 1'b0);
    check("gap out_data", 32'(bus.out_data), 32'h008);
    drain("gap");

    // A clear that coincides with a beat wins, and the beat is dropped.
    beat(9'h050, 1'b0);
    beat(9'h050, 1'b0);
    @(negedge clk);
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 9'h050;
    @(posedge clk);
    #1;
    clear = 1'b0; bus.in_valid = 1'b0;
    check("clear in_ready", 32'(bus.in_ready), 32'd1);
    run_vec(ones, 1'b1);

    // A clear in DONE drops out_valid on the next edge.
    run_vec(v1, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear done out_valid", 32'(bus.out_valid), 32'd0);
    check("clear done out_data", 32'(bus.out_data), 32'd0);
    run_vec(ones, 1'b1);

    // Asynchronous reset mid-vector and in DONE.
    beat(9'h050, 1'b0);
    beat(9'h050, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst mid in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_vec(ones, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst done out_valid", 32'(bus.out_valid), 32'd0);
    check("rst done out_data", 32'(bus.out_data), 32'd0);
    check("rst done in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_vec(ones, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
